seq_detect_n: RTL and testbench

Parametrised serial sequence detector that generalises the team's fixed 3-bit-state Mealy detectors. It compares the most recent PATTERN_W bits of a single-bit serial stream against a runtime-loadable pattern, emits a registered one-cycle `z` pulse per match, and keeps a saturating match count. Overlapping and non-overlapping detection are both supported. It sits directly on a serial input line next to the other FSM experiment blocks.

---
 rtl/seq_detect_n.sv | 95 +++++++++
 tb/tb_seq_detect_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_n.sv
// seq_detect_n
//   Serial sequence detector. Compares the most recent PATTERN_W enabled bits
//   of the x stream against a runtime-loadable pattern and emits a registered
//   one-cycle pulse on z for every match. A saturating counter tracks matches.
//   Overlapping and non-overlapping detection are selected by `overlap`.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   x        serial data bit, sampled when en=1
//   en       bit-valid qualifier
//   load     loads `pattern` into the pattern register, restarts the fill count
//   pattern  new pattern; bit [PATTERN_W-1] is the first bit received
//   overlap  1 = matched bits may be reused, 0 = each bit used at most once
//   clear    synchronous clear of count (wins over a same-cycle match)
//   z        registered match pulse
//   count    saturating match count
module seq_detect_n #(
    parameter int                   PATTERN_W = 4,
    parameter int                   CNT_W     = 8,
    parameter logic [PATTERN_W-1:0] PAT_RST   = 4'b1011
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x,
    input  logic                 en,
    input  logic                 load,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic                 overlap,
    input  logic                 clear,
    output logic                 z,
    output logic [CNT_W-1:0]     count
);

    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PATTERN_W-1:0] pat_q;
    logic [PATTERN_W-1:0] hist;
    logic [FILL_W-1:0]    fill;

    logic [PATTERN_W-1:0] hist_n;
    logic [FILL_W-1:0]    fill_n;
    logic                 match;

    // fill counts how many of the bits in hist belong to the current attempt;
    // a match requires a full window so stale history never completes one.
    always_comb begin
        hist_n = {hist[PATTERN_W-2:0], x};
        fill_n = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        match  = en && !load && (fill_n == FILL_FULL) && (hist_n == pat_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PAT_RST;
        end else if (load) begin
            pat_q <= pattern;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else if (load) begin
            fill <= '0;
            z    <= 1'b0;
        end else if (en) begin
            hist <= hist_n;
            z    <= match;
            if (match) begin
                // Non-overlap discards the whole matched window.
                fill <= overlap ? FILL_FULL : '0;
            end else begin
                fill <= fill_n;
            end
        end else begin
            z <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (match && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_n.sv
module tb_seq_detect_n;

    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          x;
    logic          en;
    logic          load;
    logic [PW-1:0] pattern;
    logic          overlap;
    logic          clear;
    logic          z;
    logic [7:0]    count;
    logic          z2;
    logic [1:0]    count2;

    int n_tests = 0;
    int n_fail  = 0;

    seq_detect_n #(.PATTERN_W(PW), .CNT_W(8), .PAT_RST(4'b1011)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .en(en), .load(load),
        .pattern(pattern), .overlap(overlap), .clear(clear),
        .z(z), .count(count)
    );

    seq_detect_n #(.PATTERN_W(PW), .CNT_W(2), .PAT_RST(4'b1011)) dut2 (
        .clk(clk), .rst_n(rst_n), .x(x), .en(en), .load(load),
        .pattern(pattern), .overlap(overlap), .clear(clear),
        .z(z2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the enabled bits of the current attempt, oldest first.
    bit            win[$];
    logic [PW-1:0] m_pat;
    int            m_cnt;
    int            m_cnt2;
    bit            exp_z;

    typedef struct {
        bit            x;
        bit            en;
        bit            ld;
        logic [PW-1:0] pat;
        bit            ovl;
        bit            clr;
        bit            ez;
        int            ec;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_pat  = 4'b1011;
        m_cnt  = 0;
        m_cnt2 = 0;
        exp_z  = 1'b0;
    endtask

    task automatic model_edge();
        bit m;
        m = 1'b0;
        if (load) begin
            m_pat = pattern;
            win.delete();
        end else if (en) begin
            win.push_back(x);
            if (win.size() > PW) void'(win.pop_front());
            if (win.size() == PW) begin
                m = 1'b1;
                for (int i = 0; i < PW; i++)
                    if (win[i] != m_pat[PW-1-i]) m = 1'b0;
            end
            if (m && !overlap) win.delete();
        end
        exp_z = m;
        if (clear) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (m) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    // One clock cycle: drive, advance the model, then compare 1 ns after the edge.
    task automatic cyc(input bit xi, input bit eni, input bit ldi, input logic [PW-1:0] pati,
                       input bit ovli, input bit clri, input string tag);
        x       = xi;
        en      = eni;
        load    = ldi;
        pattern = pati;
        overlap = ovli;
        clear   = clri;
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".z"},      z,      exp_z);
        check({tag, ".count"},  count,  m_cnt);
        check({tag, ".z2"},     z2,     exp_z);
        check({tag, ".count2"}, count2, m_cnt2);
    endtask

    // Pulse rst_n between edges and check the outputs drop without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_z"},      z,      0);
        check({tag, ".rst_count"},  count,  0);
        check({tag, ".rst_count2"}, count2, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input bit xi, input bit eni, input bit ldi, input logic [PW-1:0] pati,
                       input bit ovli, input bit clri, input bit ez, input int ec);
        vec_t v;
        v.x = xi; v.en = eni; v.ld = ldi; v.pat = pati;
        v.ovl = ovli; v.clr = clri; v.ez = ez; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic feed(input bit b, input bit ovl, input string tag);
        cyc(b, 1'b1, 1'b0, 4'b0000, ovl, 1'b0, tag);
    endtask

    initial begin
        rst_n = 1'b0; x = 1'b0; en = 1'b0; load = 1'b0;
        pattern = '0; overlap = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.z",      z,      0);
        check("reset.count",  count,  0);
        check("reset.count2", count2, 0);
        rst_n = 1'b1;

        // Overlap stream 1011011 on the reset pattern
        add(1,1,0,4'b0000,1,0, 0,0); add(0,1,0,4'b0000,1,0, 0,0);
        add(1,1,0,4'b0000,1,0, 0,0); add(1,1,0,4'b0000,1,0, 1,1);
        add(0,1,0,4'b0000,1,0, 0,1); add(1,1,0,4'b0000,1,0, 0,1);
        add(1,1,0,4'b0000,1,0, 1,2);
        add(0,0,1,4'b1011,0,0, 0,2);
        // Same stream, non-overlap
        add(1,1,0,4'b0000,0,0, 0,2); add(0,1,0,4'b0000,0,0, 0,2);
        add(1,1,0,4'b0000,0,0, 0,2); add(1,1,0,4'b0000,0,0, 1,3);
        add(0,1,0,4'b0000,0,0, 0,3); add(1,1,0,4'b0000,0,0, 0,3);
        add(1,1,0,4'b0000,0,0, 0,3);
        // 1111 overlap: three back-to-back pulses
        add(0,0,1,4'b1111,1,0, 0,3);
        for (int i = 0; i < 6; i++) add(1,1,0,4'b0000,1,0, i >= 3, 3 + ((i >= 3) ? i - 2 : 0));
        // 1111 non-overlap: one pulse
        add(0,0,1,4'b1111,0,0, 0,6);
        for (int i = 0; i < 6; i++) add(1,1,0,4'b0000,0,0, i == 3, (i >= 3) ? 7 : 6);
        // Pattern split by an en=0 gap
        add(0,0,1,4'b1011,0,0, 0,7);
        add(1,1,0,4'b0000,0,0, 0,7); add(0,1,0,4'b0000,0,0, 0,7);
        add(0,0,0,4'b0000,0,0, 0,7); add(0,0,0,4'b0000,0,0, 0,7);
        add(1,1,0,4'b0000,0,0, 0,7); add(1,1,0,4'b0000,0,0, 1,8);
        add(0,0,0,4'b0000,0,1, 0,0);

        foreach (tbl[i]) begin
            cyc(tbl[i].x, tbl[i].en, tbl[i].ld, tbl[i].pat, tbl[i].ovl, tbl[i].clr,
                $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.vec_z", i),     z,     tbl[i].ez);
            check($sformatf("tbl%0d.vec_count", i), count, tbl[i].ec);
        end

        // Reset while z is high, then reset mid-pattern
        feed(1,0,"rm"); feed(0,0,"rm"); feed(1,0,"rm"); feed(1,0,"rm");
        check("rm.match_before_reset", z, 1);
        async_reset("rm1");
        feed(1,0,"rm"); feed(0,0,"rm"); feed(1,0,"rm");
        async_reset("rm2");
        feed(1,0,"rm");
        check("rm.no_match_after_reset", z, 0);
        feed(1,0,"rm"); feed(0,0,"rm"); feed(1,0,"rm"); feed(1,0,"rm");
        check("rm.match_z", z, 1);
        check("rm.match_count", count, 1);

        // Load in the middle of a partial pattern
        feed(1,1,"ld"); feed(0,1,"ld"); feed(1,1,"ld");
        cyc(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, "ld.load");
        check("ld.load_z", z, 0);
        feed(1,1,"ld");
        check("ld.no_match", z, 0);
        feed(0,1,"ld"); feed(1,1,"ld"); feed(1,1,"ld"); feed(0,1,"ld");
        check("ld.match_0110", z, 1);

        // Saturation of the 2-bit counter, then clear racing a match
        async_reset("sat");
        cyc(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, "sat.load");
        for (int i = 0; i < 8; i++) feed(1,1,"sat");
        check("sat.count2_saturated", count2, 3);
        check("sat.count_wide", count, 5);
        cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, "clr");
        check("clr.z_pulses", z, 1);
        check("clr.count_zero", count, 0);
        check("clr.count2_zero", count2, 0);

        // Randomised traffic against the model
        begin
            bit ovl_r;
            ovl_r = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                logic [PW-1:0] p;
                if ($urandom_range(0, 99) < 5) ovl_r = ~ovl_r;
                case ($urandom_range(0, 3))
                    0:       p = 4'b1011;
                    1:       p = 4'b1111;
                    2:       p = 4'b0110;
                    default: p = 4'($urandom_range(0, 15));
                endcase
                if ($urandom_range(0, 999) < 5) async_reset("rnd");
                cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 99) < 3, p, ovl_r,
                    $urandom_range(0, 99) < 3, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
